// File: rtl/sweep_pkg.sv
// Shared types and helpers for the up/down sweep sequencer.
package sweep_pkg;

   localparam int unsigned W_DEF  = 8;
   localparam int unsigned CW_DEF = 4;
   localparam int unsigned CFG_W  = 32;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_UP   = 3'd2,
      S_DOWN = 3'd3,
      S_DONE = 3'd4
   } state_t;

   // Callers zero-extend their operands to CFG_W bits first
   function automatic logic cfg_valid(input logic [CFG_W-1:0] lo,
                                      input logic [CFG_W-1:0] hi,
                                      input logic [CFG_W-1:0] step,
                                      input logic [CFG_W-1:0] cycles);
      return (lo < hi) && (step != '0) && (cycles != '0);
   endfunction

endpackage

// File: rtl/step_counter.sv
// W-bit count register with load, add-step and subtract-step; exposes W+1-bit sum/diff.
module step_counter
   import sweep_pkg::*;
#(
   parameter int unsigned W = W_DEF
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] ld_val,
   input  logic         en,
   input  logic         up,
   input  logic [W-1:0] step,
   output logic [W-1:0] q,
   output logic [W:0]   sum,
   output logic [W:0]   diff
);

   logic [W-1:0] r_q;

   // sum[W] is the carry and diff[W] the borrow; the caller decides clamping
   assign sum  = {1'b0, r_q} + {1'b0, step};
   assign diff = {1'b0, r_q} - {1'b0, step};
   assign q    = r_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_q <= '0;
      end else if (load) begin
         r_q <= ld_val;
      end else if (en) begin
         r_q <= up ? sum[W-1:0] : diff[W-1:0];
      end
   end

endmodule

// File: rtl/sweep_counter_ctrl.sv
// Sequencer sweeping a step counter lo->hi->lo for a programmed number of sweeps.
module sweep_counter_ctrl
   import sweep_pkg::*;
#(
   parameter int unsigned W  = W_DEF,
   parameter int unsigned CW = CW_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          abort,
   input  logic [W-1:0]  lo,
   input  logic [W-1:0]  hi,
   input  logic [W-1:0]  step,
   input  logic [CW-1:0] cycles,
   output logic [W-1:0]  q,
   output logic          dir,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic          aborted
);

   state_t        r_state, w_state_nxt;
   logic [W-1:0]  r_lo, r_hi, r_step;
   logic [CW-1:0] r_rem, w_rem_nxt;
   logic          r_dir, r_busy, r_done, r_err, r_aborted;
   logic          w_dir_nxt, w_done_nxt, w_err_nxt, w_aborted_nxt, w_latch;
   logic          w_load, w_en, w_up, w_cfg_ok;
   logic [W-1:0]  w_ld_val;
   logic [W:0]    w_sum, w_diff;

   step_counter #(.W(W)) u_cnt (
      .clk    (clk),
      .reset  (reset),
      .load   (w_load),
      .ld_val (w_ld_val),
      .en     (w_en),
      .up     (w_up),
      .step   (r_step),
      .q      (q),
      .sum    (w_sum),
      .diff   (w_diff)
   );

   assign w_cfg_ok = cfg_valid(CFG_W'(lo), CFG_W'(hi), CFG_W'(step), CFG_W'(cycles));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_lo      <= '0;
         r_hi      <= '0;
         r_step    <= '0;
         r_rem     <= '0;
         r_dir     <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_aborted <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_rem     <= w_rem_nxt;
         r_dir     <= w_dir_nxt;
         r_busy    <= (w_state_nxt != S_IDLE);
         r_done    <= w_done_nxt;
         r_err     <= w_err_nxt;
         r_aborted <= w_aborted_nxt;
         if (w_latch) begin
            r_lo   <= lo;
            r_hi   <= hi;
            r_step <= step;
         end
      end
   end

   // Next state, counter control and pulse outputs; all clamping compares are W+1 bits
   always_comb begin
      w_state_nxt   = r_state;
      w_rem_nxt     = r_rem;
      w_dir_nxt     = r_dir;
      w_done_nxt    = 1'b0;
      w_err_nxt     = 1'b0;
      w_aborted_nxt = 1'b0;
      w_latch       = 1'b0;
      w_load        = 1'b0;
      w_ld_val      = r_lo;
      w_en          = 1'b0;
      w_up          = 1'b0;

      if (r_state != S_IDLE && abort) begin
         w_state_nxt   = S_IDLE;
         w_aborted_nxt = 1'b1;
         w_dir_nxt     = 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  if (w_cfg_ok) begin
                     w_latch     = 1'b1;
                     w_rem_nxt   = cycles;
                     w_state_nxt = S_LOAD;
                  end else begin
                     w_err_nxt = 1'b1;
                  end
               end
            end
            S_LOAD: begin
               w_load      = 1'b1;
               w_ld_val    = r_lo;
               w_dir_nxt   = 1'b1;
               w_state_nxt = S_UP;
            end
            S_UP: begin
               if (w_sum >= {1'b0, r_hi}) begin
                  w_load      = 1'b1;
                  w_ld_val    = r_hi;
                  w_dir_nxt   = 1'b0;
                  w_state_nxt = S_DOWN;
               end else begin
                  w_en = 1'b1;
                  w_up = 1'b1;
               end
            end
            S_DOWN: begin
               if (w_diff[W] || (w_diff <= {1'b0, r_lo})) begin
                  w_load    = 1'b1;
                  w_ld_val  = r_lo;
                  w_rem_nxt = r_rem - CW'(1);
                  if (r_rem == CW'(1)) begin
                     w_done_nxt  = 1'b1;
                     w_state_nxt = S_DONE;
                  end else begin
                     w_dir_nxt   = 1'b1;
                     w_state_nxt = S_UP;
                  end
               end else begin
                  w_en = 1'b1;
               end
            end
            S_DONE: begin
               w_state_nxt = S_IDLE;
            end
            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

   assign dir     = r_dir;
   assign busy    = r_busy;
   assign done    = r_done;
   assign err     = r_err;
   assign aborted = r_aborted;

endmodule

// File: tb/tb_sweep_counter_ctrl.sv
// Directed bench for sweep_counter_ctrl: sweeps, bad configs, abort, reset, busy-start.
module tb_sweep_counter_ctrl;

   logic       clk;
   logic       reset;
   logic       start;
   logic       abort;
   logic [7:0] lo, hi, step;
   logic [3:0] cycles;
   logic [7:0] q;
   logic       dir, busy, done, err, aborted;

   int n_vec;
   int n_err;

   sweep_counter_ctrl #(.W(8), .CW(4)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .abort   (abort),
      .lo      (lo),
      .hi      (hi),
      .step    (step),
      .cycles  (cycles),
      .q       (q),
      .dir     (dir),
      .busy    (busy),
      .done    (done),
      .err     (err),
      .aborted (aborted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cfg(input logic [7:0] l, input logic [7:0] h,
                          input logic [7:0] s, input logic [3:0] c);
      lo = l; hi = h; step = s; cycles = c;
   endtask

   // Starts a sweep and checks q/dir every cycle from LOAD until back in IDLE
   task automatic run_sweep(input string name, input int n,
                            input logic [7:0] eq [16], input logic [15:0] ed);
      int ndone;
      ndone = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      n_vec++;
      if (busy !== 1'b1) begin
         n_err++; $display("FAIL %s busy_after_start got=%b exp=1", name, busy);
      end
      for (int i = 0; i < n; i++) begin
         tick();
         if (done === 1'b1) ndone++;
         n_vec++;
         if (q !== eq[i] || dir !== ed[i]) begin
            n_err++;
            $display("FAIL %s step%0d q/dir got=%0d/%b exp=%0d/%b", name, i, q, dir, eq[i], ed[i]);
         end
      end
      n_vec++;
      if (done !== 1'b1 || busy !== 1'b1) begin
         n_err++; $display("FAIL %s done_cycle done/busy got=%b/%b exp=1/1", name, done, busy);
      end
      tick();
      n_vec++;
      if (busy !== 1'b0 || done !== 1'b0 || q !== eq[n-1]) begin
         n_err++;
         $display("FAIL %s end busy/done/q got=%b/%b/%0d exp=0/0/%0d", name, busy, done, q, eq[n-1]);
      end
      n_vec++;
      if (ndone != 1) begin
         n_err++; $display("FAIL %s done_count got=%0d exp=1", name, ndone);
      end
   endtask

   task automatic test_reset();
      n_vec++;
      if (q !== 8'd0 || dir !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
          err !== 1'b0 || aborted !== 1'b0) begin
         n_err++;
         $display("FAIL reset q/dir/busy/done/err/aborted got=%0d/%b/%b/%b/%b/%b exp=0/0/0/0/0/0",
                  q, dir, busy, done, err, aborted);
      end
   endtask

   task automatic test_sweep_t1();
      logic [7:0] eq [16];
      eq = '{8'd10, 8'd14, 8'd18, 8'd20, 8'd16, 8'd12, 8'd10,
             8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
      set_cfg(8'd10, 8'd20, 8'd4, 4'd1);
      // bit i = dir after step i
      run_sweep("t1", 7, eq, 16'b0000_0000_0000_0111);
   endtask

   task automatic test_sweep_t2();
      logic [7:0] eq [16];
      eq = '{8'd0, 8'd200, 8'd255, 8'd55, 8'd0, 8'd200, 8'd255, 8'd55, 8'd0,
             8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
      set_cfg(8'd0, 8'd255, 8'd200, 4'd2);
      run_sweep("t2", 9, eq, 16'b0000_0000_0011_0011);
   endtask

   task automatic test_bad_cfg(input logic [7:0] exp_q);
      logic [7:0] bl [4], bh [4], bs [4];
      logic [3:0] bc [4];
      bl = '{8'd30, 8'd10, 8'd10, 8'd40};
      bh = '{8'd30, 8'd20, 8'd20, 8'd35};
      bs = '{8'd4,  8'd0,  8'd4,  8'd1};
      bc = '{4'd1,  4'd1,  4'd0,  4'd1};
      for (int i = 0; i < 4; i++) begin
         set_cfg(bl[i], bh[i], bs[i], bc[i]);
         start = 1'b1;
         tick();
         start = 1'b0;
         n_vec++;
         if (err !== 1'b1 || busy !== 1'b0 || q !== exp_q) begin
            n_err++;
            $display("FAIL bad_cfg%0d err/busy/q got=%b/%b/%0d exp=1/0/%0d", i, err, busy, q, exp_q);
         end
         tick();
         n_vec++;
         if (err !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL bad_cfg%0d_after err/busy got=%b/%b exp=0/0", i, err, busy);
         end
      end
   endtask

   task automatic test_abort();
      set_cfg(8'd10, 8'd20, 8'd4, 4'd1);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      n_vec++;
      if (q !== 8'd18) begin
         n_err++; $display("FAIL abort_pre q got=%0d exp=18", q);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      n_vec++;
      if (aborted !== 1'b1 || busy !== 1'b0 || q !== 8'd18 || done !== 1'b0) begin
         n_err++;
         $display("FAIL abort aborted/busy/q/done got=%b/%b/%0d/%b exp=1/0/18/0", aborted, busy, q, done);
      end
      for (int i = 0; i < 8; i++) begin
         tick();
         n_vec++;
         if (aborted !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || q !== 8'd18) begin
            n_err++;
            $display("FAIL abort_idle%0d aborted/done/busy/q got=%b/%b/%b/%0d exp=0/0/0/18",
                     i, aborted, done, busy, q);
         end
      end
   endtask

   task automatic test_reset_mid();
      set_cfg(8'd10, 8'd20, 8'd4, 4'd1);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      n_vec++;
      if (q !== 8'd16 || dir !== 1'b0) begin
         n_err++; $display("FAIL reset_mid_pre q/dir got=%0d/%b exp=16/0", q, dir);
      end
      #1 reset = 1'b1;
      #1;
      n_vec++;
      if (q !== 8'd0 || dir !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
          err !== 1'b0 || aborted !== 1'b0) begin
         n_err++;
         $display("FAIL reset_mid q/dir/busy/done/err/aborted got=%0d/%b/%b/%b/%b/%b exp=0/0/0/0/0/0",
                  q, dir, busy, done, err, aborted);
      end
      #1 reset = 1'b0;
      tick();
      n_vec++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_err++; $display("FAIL reset_mid_after busy/done got=%b/%b exp=0/0", busy, done);
      end
      test_sweep_t1();
   endtask

   task automatic test_back_to_back();
      logic [7:0] eq [6];
      eq = '{8'd10, 8'd14, 8'd18, 8'd20, 8'd16, 8'd12};
      set_cfg(8'd10, 8'd20, 8'd4, 4'd1);
      start = 1'b1;
      tick();
      // hold start and scramble config while busy
      set_cfg(8'd0, 8'd100, 8'd1, 4'd5);
      for (int i = 0; i < 6; i++) begin
         tick();
         n_vec++;
         if (q !== eq[i] || err !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL busy_start%0d q/err/busy got=%0d/%b/%b exp=%0d/0/1", i, q, err, busy, eq[i]);
         end
      end
      start = 1'b0;
      tick();
      n_vec++;
      if (q !== 8'd10 || done !== 1'b1) begin
         n_err++; $display("FAIL busy_start_done q/done got=%0d/%b exp=10/1", q, done);
      end
      tick();
      n_vec++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_err++; $display("FAIL busy_start_idle busy/done got=%b/%b exp=0/0", busy, done);
      end
      set_cfg(8'd50, 8'd60, 8'd20, 4'd1);
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      n_vec++;
      if (busy !== 1'b1 || aborted !== 1'b0) begin
         n_err++; $display("FAIL start_abort busy/aborted got=%b/%b exp=1/0", busy, aborted);
      end
      // step >= hi-lo: single-step ramps 50 -> 60 -> 50
      tick();
      n_vec++;
      if (q !== 8'd50 || dir !== 1'b1) begin
         n_err++; $display("FAIL start_abort_load q/dir got=%0d/%b exp=50/1", q, dir);
      end
      tick();
      n_vec++;
      if (q !== 8'd60 || dir !== 1'b0) begin
         n_err++; $display("FAIL big_step_up q/dir got=%0d/%b exp=60/0", q, dir);
      end
      tick();
      n_vec++;
      if (q !== 8'd50 || done !== 1'b1) begin
         n_err++; $display("FAIL big_step_down q/done got=%0d/%b exp=50/1", q, done);
      end
      tick();
      n_vec++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_err++; $display("FAIL big_step_end busy/done got=%b/%b exp=0/0", busy, done);
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      reset = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      set_cfg(8'd0, 8'd0, 8'd0, 4'd0);
      #12;
      test_reset();
      reset = 1'b0;
      tick();
      test_sweep_t1();
      test_sweep_t2();
      test_bad_cfg(8'd0);
      test_abort();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
